// File: rtl/bp_ctrl_pkg.sv
// Shared types and helpers for the branch-predictor update controller:
// update FSM states, the resolved-branch record, gskew hashing and
// 2-bit saturating counter arithmetic.
package bp_ctrl_pkg;

    localparam int BP_PC_W   = 32;
    localparam int BP_GHR_W  = 8;
    localparam int BP_IDX_W  = 3;
    localparam int NUM_BANKS = 3;
    localparam int CTR_W     = 2;

    typedef logic [$clog2(NUM_BANKS)-1:0] bank_t;
    typedef logic [CTR_W-1:0]             ctr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_WR0,
        S_RD1,
        S_WR1,
        S_RD2,
        S_WR2,
        S_BTB
    } upd_state_t;

    typedef struct packed {
        logic [BP_PC_W-1:0]  pc;
        logic [BP_PC_W-1:0]  target;
        logic                taken;
        logic [BP_GHR_W-1:0] ghr;
    } branch_rec_t;

    // Bank addressed by each counter read/write state.
    function automatic bank_t state_bank(input upd_state_t s);
        bank_t b;
        case (s)
            S_RD1, S_WR1: b = bank_t'(1);
            S_RD2, S_WR2: b = bank_t'(2);
            default:      b = bank_t'(0);
        endcase
        return b;
    endfunction

    // gskew hash: PC word bits XOR a per-bank skew of the low history bits.
    function automatic logic [BP_IDX_W-1:0] gskew_index(
        input logic [BP_PC_W-1:0]  pc,
        input logic [BP_GHR_W-1:0] ghr,
        input bank_t               bank
    );
        logic [BP_IDX_W-1:0] p;
        logic [BP_IDX_W-1:0] g;
        logic [BP_IDX_W-1:0] h;
        p = pc[BP_IDX_W+1:2];
        g = ghr[BP_IDX_W-1:0];
        if (bank == bank_t'(1)) begin
            h = {g[BP_IDX_W-2:0], g[BP_IDX_W-1]};
        end else if (bank == bank_t'(2)) begin
            h = {g[0], g[BP_IDX_W-1:1]};
        end else begin
            h = g;
        end
        return p ^ h;
    endfunction

    function automatic ctr_t sat_inc(input ctr_t c);
        return (c == '1) ? c : c + ctr_t'(1);
    endfunction

    function automatic ctr_t sat_dec(input ctr_t c);
        return (c == '0) ? c : c - ctr_t'(1);
    endfunction

endpackage

// File: rtl/branch_rec_fifo.sv
// Small synchronous FIFO of resolved-branch records. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module branch_rec_fifo
    import bp_ctrl_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  branch_rec_t push_data_i,
    input  logic        pop_i,
    output branch_rec_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    branch_rec_t     mem_q [DEPTH];
    logic [AW:0]     wr_ptr_q;
    logic [AW:0]     rd_ptr_q;
    logic            do_push;
    logic            do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Record storage, written at the tail.
    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    // Head/tail pointer advance.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/predictor_update_controller.sv
// Sequences branch-prediction state updates after execution resolves a
// branch: buffers records, read-modify-writes the three gskew counter
// banks through a port shared with fetch, writes taken branches into the
// BTB, and drives misprediction recovery (flush, redirect, GHR restore).
module predictor_update_controller
    import bp_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    // Record widths come from bp_ctrl_pkg; override these only together with the package.
    parameter int PC_W         = BP_PC_W,
    parameter int GHR_W        = BP_GHR_W,
    parameter int IDX_W        = BP_IDX_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [PC_W-1:0]   res_pc,
    input  logic [PC_W-1:0]   res_target,
    input  logic              res_taken,
    input  logic              res_predicted,
    input  logic [GHR_W-1:0]  res_ghr,
    input  logic              fetch_lookup,
    output logic              ctr_rd_en,
    output logic              ctr_wr_en,
    output logic [1:0]        ctr_bank,
    output logic [IDX_W-1:0]  ctr_idx,
    output logic [1:0]        ctr_wdata,
    input  logic [1:0]        ctr_rdata,
    output logic              btb_we,
    output logic [2*PC_W-1:0] btb_tag_and_target,
    output logic              flush_pipeline,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              ghr_restore,
    output logic [GHR_W-1:0]  ghr_restore_value,
    output logic              busy
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);

    // Record buffer
    branch_rec_t push_rec;
    branch_rec_t head_rec;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;

    // Recovery state
    logic             out_of_reset_q;
    logic [FC_W-1:0]  flush_cnt_q;
    logic             flush_active;
    logic [PC_W-1:0]  redirect_pc_q;
    logic             ghr_restore_q;
    logic [GHR_W-1:0] ghr_restore_value_q;
    logic             accept;
    logic             mispredict;

    // Update state
    upd_state_t  state_q;
    branch_rec_t work_q;
    ctr_t        rdata_q;
    logic        rdata_held_q;
    logic        in_rd;
    logic        in_wr;
    bank_t       cur_bank;
    ctr_t        rd_value;

    assign flush_active = (flush_cnt_q != '0);
    // Wrong-path records offered during a flush are refused and thereby dropped.
    assign res_ready    = out_of_reset_q && !fifo_full && !flush_active;
    assign accept       = res_valid && res_ready;
    assign mispredict   = accept && (res_taken != res_predicted);
    assign push_rec     = '{pc: res_pc, target: res_target, taken: res_taken, ghr: res_ghr};
    assign fifo_pop     = (state_q == S_IDLE) && !fifo_empty;

    branch_rec_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (accept),
        .push_data_i (push_rec),
        .pop_i       (fifo_pop),
        .head_o      (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Misprediction recovery: flush countdown, redirect target and GHR restore pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_of_reset_q      <= 1'b0;
            flush_cnt_q         <= '0;
            redirect_pc_q       <= '0;
            ghr_restore_q       <= 1'b0;
            ghr_restore_value_q <= '0;
        end else begin
            out_of_reset_q <= 1'b1;
            ghr_restore_q  <= mispredict;
            if (mispredict) begin
                flush_cnt_q         <= FC_W'(FLUSH_CYCLES);
                redirect_pc_q       <= res_taken ? res_target : res_pc + PC_W'(4);
                ghr_restore_value_q <= {res_ghr[GHR_W-2:0], res_taken};
            end else if (flush_active) begin
                flush_cnt_q <= flush_cnt_q - FC_W'(1);
            end
        end
    end

    assign flush_pipeline    = flush_active;
    assign redirect_pc       = redirect_pc_q;
    assign ghr_restore       = ghr_restore_q;
    assign ghr_restore_value = ghr_restore_value_q;

    // Decode of the current update step; strobes are gated by fetch_lookup in the same
    // cycle, so fetch wins the counter port without a cycle of latency.
    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned (no latch).
        in_rd    = 1'b0;
        in_wr    = 1'b0;
        cur_bank = state_bank(state_q);
        case (state_q)
            S_RD0, S_RD1, S_RD2: in_rd = 1'b1;
            S_WR0, S_WR1, S_WR2: in_wr = 1'b1;
            default: ;
        endcase
    end

    // Counter value read one cycle earlier, or the copy held across a stall.
    assign rd_value  = rdata_held_q ? rdata_q : ctr_rdata;

    assign ctr_rd_en = in_rd && !fetch_lookup;
    assign ctr_wr_en = in_wr && !fetch_lookup;
    assign ctr_bank  = (in_rd || in_wr) ? cur_bank : '0;
    assign ctr_idx   = (in_rd || in_wr) ? gskew_index(work_q.pc, work_q.ghr, cur_bank) : '0;
    assign ctr_wdata = in_wr ? (work_q.taken ? sat_inc(rd_value) : sat_dec(rd_value)) : '0;

    assign btb_we             = (state_q == S_BTB) && work_q.taken;
    assign btb_tag_and_target = (state_q == S_BTB) ? {work_q.pc, work_q.target} : '0;

    assign busy = !fifo_empty || (state_q != S_IDLE);

    // Update FSM: one read-modify-write per bank, then the BTB step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            work_q       <= '0;
            rdata_q      <= '0;
            rdata_held_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        work_q  <= head_rec;
                        state_q <= S_RD0;
                    end
                end
                S_RD0: if (!fetch_lookup) state_q <= S_WR0;
                S_RD1: if (!fetch_lookup) state_q <= S_WR1;
                S_RD2: if (!fetch_lookup) state_q <= S_WR2;
                S_WR0, S_WR1, S_WR2: begin
                    if (fetch_lookup) begin
                        // Read data is only valid on the first write cycle; keep it.
                        rdata_q      <= rd_value;
                        rdata_held_q <= 1'b1;
                    end else begin
                        rdata_held_q <= 1'b0;
                        case (state_q)
                            S_WR0:   state_q <= S_RD1;
                            S_WR1:   state_q <= S_RD2;
                            default: state_q <= S_BTB;
                        endcase
                    end
                end
                S_BTB:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_predictor_update_controller.sv
// Directed bench for predictor_update_controller: correct prediction,
// mispredict recovery, port contention, saturation, FIFO full ordering
// and reset during an update.
`timescale 1ns/1ps
module tb_predictor_update_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_pc;
    logic [31:0] res_target;
    logic        res_taken;
    logic        res_predicted;
    logic [7:0]  res_ghr;
    logic        fetch_lookup;
    logic        ctr_rd_en;
    logic        ctr_wr_en;
    logic [1:0]  ctr_bank;
    logic [2:0]  ctr_idx;
    logic [1:0]  ctr_wdata;
    logic [1:0]  ctr_rdata;
    logic        btb_we;
    logic [63:0] btb_tag_and_target;
    logic        flush_pipeline;
    logic [31:0] redirect_pc;
    logic        ghr_restore;
    logic [7:0]  ghr_restore_value;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;
    int n_viol  = 0;

    predictor_update_controller #(
        .FIFO_DEPTH   (4),
        .PC_W         (32),
        .GHR_W        (8),
        .IDX_W        (3),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .res_valid          (res_valid),
        .res_ready          (res_ready),
        .res_pc             (res_pc),
        .res_target         (res_target),
        .res_taken          (res_taken),
        .res_predicted      (res_predicted),
        .res_ghr            (res_ghr),
        .fetch_lookup       (fetch_lookup),
        .ctr_rd_en          (ctr_rd_en),
        .ctr_wr_en          (ctr_wr_en),
        .ctr_bank           (ctr_bank),
        .ctr_idx            (ctr_idx),
        .ctr_wdata          (ctr_wdata),
        .ctr_rdata          (ctr_rdata),
        .btb_we             (btb_we),
        .btb_tag_and_target (btb_tag_and_target),
        .flush_pipeline     (flush_pipeline),
        .redirect_pc        (redirect_pc),
        .ghr_restore        (ghr_restore),
        .ghr_restore_value  (ghr_restore_value),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Counter-port exclusivity, sampled mid-cycle.
    always @(negedge clk) begin
        if ((ctr_rd_en && ctr_wr_en) || (fetch_lookup && (ctr_rd_en || ctr_wr_en))) begin
            n_viol++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic tk, input logic pr, input logic [7:0] ghr);
        res_valid     = 1'b1;
        res_pc        = pc;
        res_target    = tgt;
        res_taken     = tk;
        res_predicted = pr;
        res_ghr       = ghr;
    endtask

    // Expects an uncontended read then write on one bank; ends one cycle later.
    task automatic rmw(input string tag, input int bank, input int idx, input int wdata);
        #1;
        chk({tag, " rd strobes"}, 64'({ctr_rd_en, ctr_wr_en}), 64'(2'b10));
        chk({tag, " rd bank/idx"}, 64'({ctr_bank, ctr_idx}), 64'({2'(bank), 3'(idx)}));
        tick();
        #1;
        chk({tag, " wr strobes"}, 64'({ctr_rd_en, ctr_wr_en}), 64'(2'b01));
        chk({tag, " wr bank/idx/data"}, 64'({ctr_bank, ctr_idx, ctr_wdata}),
            64'({2'(bank), 3'(idx), 2'(wdata)}));
        tick();
    endtask

    task automatic btb_chk(input string tag, input logic we, input logic [63:0] data);
        #1;
        chk({tag, " btb_we"}, 64'(btb_we), 64'(we));
        chk({tag, " btb data"}, btb_tag_and_target, data);
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " ctl"}, 64'({res_ready, ctr_rd_en, ctr_wr_en, btb_we,
                                flush_pipeline, ghr_restore, busy}), 64'(0));
        chk({tag, " ctr bus"}, 64'({ctr_bank, ctr_idx, ctr_wdata}), 64'(0));
        chk({tag, " btb bus"}, btb_tag_and_target, 64'(0));
        chk({tag, " redirect/ghr"}, 64'({redirect_pc, ghr_restore_value}), 64'(0));
    endtask

    initial begin
        int strobes;

        reset         = 1'b1;
        res_valid     = 1'b0;
        res_pc        = '0;
        res_target    = '0;
        res_taken     = 1'b0;
        res_predicted = 1'b0;
        res_ghr       = '0;
        fetch_lookup  = 1'b0;
        ctr_rdata     = '0;

        // Reset state
        #2;
        chk_all_zero("reset");
        tick();
        reset = 1'b0;
        #1 chk("ready before first edge", 64'(res_ready), 64'(0));
        tick();
        #1 chk("ready after first edge", 64'({res_ready, busy}), 64'(2'b10));

        // 1: correct prediction, pc 0x40 ghr 0x05 -> idx 5/3/6, rdata 1 -> write 2
        offer(32'h40, 32'h80, 1'b1, 1'b1, 8'h05);
        ctr_rdata = 2'd1;
        #1 chk("t1 ready", 64'(res_ready), 64'(1));
        tick();
        res_valid = 1'b0;
        #1;
        chk("t1 queued busy", 64'(busy), 64'(1));
        chk("t1 no flush", 64'({flush_pipeline, ghr_restore}), 64'(0));
        chk("t1 idle no strobe", 64'({ctr_rd_en, ctr_wr_en}), 64'(0));
        tick();
        rmw("t1 b0", 0, 5, 2);
        rmw("t1 b1", 1, 3, 2);
        rmw("t1 b2", 2, 6, 2);
        btb_chk("t1", 1'b1, {32'h40, 32'h80});
        #1 chk("t1 done", 64'(busy), 64'(0));

        // 2: mispredict, pc 0x100 ghr 0x3C not taken -> redirect 0x104, restore 0x78
        offer(32'h100, 32'h200, 1'b0, 1'b1, 8'h3C);
        ctr_rdata = 2'd2;
        #1 chk("t2 ready", 64'(res_ready), 64'(1));
        tick();
        offer(32'hDEAD0, 32'hBEEF0, 1'b1, 1'b0, 8'hFF);
        #1;
        chk("t2 flush c1", 64'({flush_pipeline, ghr_restore, res_ready}), 64'(3'b110));
        chk("t2 redirect c1", 64'(redirect_pc), 64'(32'h104));
        chk("t2 ghr value", 64'(ghr_restore_value), 64'(8'h78));
        tick();
        #1;
        chk("t2 flush c2", 64'({flush_pipeline, ghr_restore, res_ready}), 64'(3'b100));
        chk("t2 redirect c2", 64'(redirect_pc), 64'(32'h104));
        res_valid = 1'b0;
        rmw("t2 b0", 0, 4, 1);
        chk("t2 flush ended", 64'({flush_pipeline, res_ready}), 64'(2'b01));
        rmw("t2 b1", 1, 1, 1);
        rmw("t2 b2", 2, 2, 1);
        btb_chk("t2", 1'b0, {32'h100, 32'h200});
        #1 chk("t2 wrong-path dropped", 64'(busy), 64'(0));

        // 3: contention during WR1, pc 0x44 ghr 0x02 -> idx 3/5/0, rdata 2 -> write 3
        offer(32'h44, 32'h88, 1'b1, 1'b1, 8'h02);
        ctr_rdata = 2'd2;
        #1 chk("t3 ready", 64'(res_ready), 64'(1));
        tick();
        res_valid = 1'b0;
        tick();
        rmw("t3 b0", 0, 3, 3);
        #1;
        chk("t3 rd1 strobes", 64'({ctr_rd_en, ctr_wr_en}), 64'(2'b10));
        chk("t3 rd1 bank/idx", 64'({ctr_bank, ctr_idx}), 64'({2'd1, 3'd5}));
        tick();
        fetch_lookup = 1'b1;
        #1 chk("t3 stall c1", 64'({ctr_rd_en, ctr_wr_en, btb_we}), 64'(0));
        tick();
        ctr_rdata = 2'd0;
        #1 chk("t3 stall c2", 64'({ctr_rd_en, ctr_wr_en, btb_we}), 64'(0));
        tick();
        #1 chk("t3 stall c3", 64'({ctr_rd_en, ctr_wr_en, btb_we}), 64'(0));
        tick();
        fetch_lookup = 1'b0;
        #1;
        chk("t3 wr1 strobes", 64'({ctr_rd_en, ctr_wr_en}), 64'(2'b01));
        chk("t3 wr1 held data", 64'({ctr_bank, ctr_idx, ctr_wdata}), 64'({2'd1, 3'd5, 2'd3}));
        tick();
        ctr_rdata = 2'd2;
        rmw("t3 b2", 2, 0, 3);
        btb_chk("t3", 1'b1, {32'h44, 32'h88});

        // 4: saturation, back-to-back: taken at 3 stays 3, not-taken at 0 stays 0
        offer(32'h48, 32'h90, 1'b1, 1'b1, 8'h00);
        ctr_rdata = 2'd3;
        #1 chk("t4a ready", 64'(res_ready), 64'(1));
        tick();
        offer(32'h4C, 32'h98, 1'b0, 1'b0, 8'h00);
        #1 chk("t4b ready", 64'(res_ready), 64'(1));
        tick();
        res_valid = 1'b0;
        rmw("t4a b0", 0, 2, 3);
        rmw("t4a b1", 1, 2, 3);
        rmw("t4a b2", 2, 2, 3);
        btb_chk("t4a", 1'b1, {32'h48, 32'h90});
        #1 chk("t4 gap idle", 64'({busy, ctr_rd_en, ctr_wr_en}), 64'(3'b100));
        tick();
        ctr_rdata = 2'd0;
        rmw("t4b b0", 0, 3, 0);
        rmw("t4b b1", 1, 3, 0);
        rmw("t4b b2", 2, 3, 0);
        btb_chk("t4b", 1'b0, {32'h4C, 32'h98});
        #1 chk("t4 done", 64'(busy), 64'(0));

        // 5: FIFO full while fetch holds the port; r0 occupies the FSM, r1..r4 fill, r5 refused
        fetch_lookup = 1'b1;
        ctr_rdata    = 2'd1;
        offer(32'h1000, 32'h2000, 1'b1, 1'b1, 8'h00);
        #1 chk("t5 r0 ready", 64'(res_ready), 64'(1));
        tick();
        res_valid = 1'b0;
        tick();
        #1 chk("t5 stalled rd", 64'(ctr_rd_en), 64'(0));
        for (int k = 1; k < 5; k++) begin
            offer(32'h1000 + 32'(4 * k), 32'h2000 + 32'(4 * k), 1'b1, 1'b1, 8'h00);
            #1 chk($sformatf("t5 r%0d ready", k), 64'(res_ready), 64'(1));
            tick();
        end
        offer(32'h1014, 32'h2014, 1'b1, 1'b1, 8'h00);
        #1 chk("t5 full ready", 64'({res_ready, ctr_rd_en}), 64'(0));
        tick();
        #1 chk("t5 still full", 64'({res_ready, busy}), 64'(2'b01));
        res_valid    = 1'b0;
        fetch_lookup = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rmw($sformatf("t5 r%0d b0", k), 0, k, 2);
            rmw($sformatf("t5 r%0d b1", k), 1, k, 2);
            rmw($sformatf("t5 r%0d b2", k), 2, k, 2);
            btb_chk($sformatf("t5 r%0d", k), 1'b1,
                    {32'h1000 + 32'(4 * k), 32'h2000 + 32'(4 * k)});
            if (k < 4) begin
                #1 chk($sformatf("t5 gap %0d", k), 64'(busy), 64'(1));
                tick();
            end
        end
        #1 chk("t5 drained", 64'(busy), 64'(0));

        // 6: reset asserted in WR0
        offer(32'h40, 32'h80, 1'b1, 1'b1, 8'h05);
        ctr_rdata = 2'd1;
        #1 chk("t6 ready", 64'(res_ready), 64'(1));
        tick();
        res_valid = 1'b0;
        tick();
        #1 chk("t6 rd0", 64'(ctr_rd_en), 64'(1));
        tick();
        #1 chk("t6 wr0", 64'(ctr_wr_en), 64'(1));
        reset = 1'b1;
        #1 chk_all_zero("t6 reset");
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ctr_wr_en || btb_we) strobes++;
        end
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (ctr_wr_en || btb_we || ctr_rd_en) strobes++;
        end
        chk("t6 no strobes after reset", 64'(strobes), 64'(0));
        chk("t6 idle after reset", 64'({res_ready, busy}), 64'(2'b10));

        chk("port exclusivity", 64'(n_viol), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
